// File: rtl/dlx_hazard_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : dlx_hazard_unit_pkg                                        |
// | Brief   : Shared constants and types for the DLX hazard unit.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package dlx_hazard_unit_pkg;

  localparam int REG_ZERO = 0;

  typedef struct packed {
    logic stall_if_id;
    logic bubble_ex;
    logic kill_if;
  } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/dlx_hazard_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : dlx_hazard_unit_if                                         |
// | Brief   : ID-stage operand/control bundle between pipeline and unit. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface dlx_hazard_unit_if #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int DEPTH = 3,
  parameter int CNT_W = 16
);
  logic                    id_valid;
  logic [RA_W-1:0]         id_rs1_sel;
  logic                    id_rs1_used;
  logic [RA_W-1:0]         id_rs2_sel;
  logic                    id_rs2_used;
  logic [RA_W-1:0]         id_rd_sel;
  logic                    id_reg_write;
  logic                    id_is_load;
  logic                    id_branch_taken;
  logic                    ex_busy;
  logic [DEPTH*XLEN-1:0]   stage_data;

  logic                    rs1_fwd_en;
  logic [XLEN-1:0]         rs1_fwd_data;
  logic                    rs2_fwd_en;
  logic [XLEN-1:0]         rs2_fwd_data;
  logic                    stall_if_id;
  logic                    bubble_ex;
  logic                    kill_if;
  logic [CNT_W-1:0]        stall_count;
  logic [CNT_W-1:0]        kill_count;

  modport master (
    output id_valid, id_rs1_sel, id_rs1_used, id_rs2_sel, id_rs2_used,
           id_rd_sel, id_reg_write, id_is_load, id_branch_taken, ex_busy,
           stage_data,
    input  rs1_fwd_en, rs1_fwd_data, rs2_fwd_en, rs2_fwd_data,
           stall_if_id, bubble_ex, kill_if, stall_count, kill_count
  );

  modport slave (
    input  id_valid, id_rs1_sel, id_rs1_used, id_rs2_sel, id_rs2_used,
           id_rd_sel, id_reg_write, id_is_load, id_branch_taken, ex_busy,
           stage_data,
    output rs1_fwd_en, rs1_fwd_data, rs2_fwd_en, rs2_fwd_data,
           stall_if_id, bubble_ex, kill_if, stall_count, kill_count
  );
endinterface
`default_nettype wire

// File: rtl/dlx_hazard_unit_fwd_match.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : dlx_hazard_unit_fwd_match                                  |
// | Brief   : Per-source priority matcher over the in-flight scoreboard. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module dlx_hazard_unit_fwd_match
  import dlx_hazard_unit_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int RA_W     = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_RDY = 1
) (
  input  logic [RA_W-1:0]             src_sel,
  input  logic                        src_used,
  input  logic [DEPTH-1:0]            ent_vld,
  input  logic [DEPTH-1:0][RA_W-1:0]  ent_rd,
  input  logic [DEPTH-1:0]            ent_load,
  input  logic [DEPTH*XLEN-1:0]       stage_data,
  output logic                        hit,
  output logic                        ready,
  output logic [XLEN-1:0]             data
);

  logic [DEPTH-1:0] w_match;
  logic             w_src_live;

  assign w_src_live = src_used && (src_sel != RA_W'(REG_ZERO));

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      assign w_match[gi] = w_src_live && ent_vld[gi] && (ent_rd[gi] == src_sel);
    end
  endgenerate

  // Scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    hit   = 1'b0;
    ready = 1'b0;
    data  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        hit   = 1'b1;
        ready = !(ent_load[i] && (i < LOAD_RDY));
        data  = stage_data[i*XLEN +: XLEN];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dlx_hazard_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : dlx_hazard_unit                                            |
// | Brief   : DLX scoreboard, operand forwarding, stall/kill, counters.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module dlx_hazard_unit
  import dlx_hazard_unit_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int RA_W     = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_RDY = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  dlx_hazard_unit_if.slave  hif
);

  generate
    if (DEPTH < 2) begin : g_bad_depth
      $error("dlx_hazard_unit: DEPTH must be at least 2");
    end
    if (LOAD_RDY >= DEPTH) begin : g_bad_load_rdy
      $error("dlx_hazard_unit: LOAD_RDY must be below DEPTH");
    end
  endgenerate

  logic [DEPTH-1:0]            r_vld;
  logic [DEPTH-1:0]            r_load;
  logic [DEPTH-1:0][RA_W-1:0]  r_rd;
  logic [CNT_W-1:0]            r_stall_cnt;
  logic [CNT_W-1:0]            r_kill_cnt;

  logic            w_rs1_hit, w_rs1_rdy, w_rs2_hit, w_rs2_rdy;
  logic [XLEN-1:0] w_rs1_data, w_rs2_data;
  logic            w_hazard;
  logic            w_issue;
  ctrl_t           w_ctrl;

  dlx_hazard_unit_fwd_match #(
    .XLEN(XLEN), .RA_W(RA_W), .DEPTH(DEPTH), .LOAD_RDY(LOAD_RDY)
  ) u_rs1_match (
    .src_sel    (hif.id_rs1_sel),
    .src_used   (hif.id_rs1_used),
    .ent_vld    (r_vld),
    .ent_rd     (r_rd),
    .ent_load   (r_load),
    .stage_data (hif.stage_data),
    .hit        (w_rs1_hit),
    .ready      (w_rs1_rdy),
    .data       (w_rs1_data)
  );

  dlx_hazard_unit_fwd_match #(
    .XLEN(XLEN), .RA_W(RA_W), .DEPTH(DEPTH), .LOAD_RDY(LOAD_RDY)
  ) u_rs2_match (
    .src_sel    (hif.id_rs2_sel),
    .src_used   (hif.id_rs2_used),
    .ent_vld    (r_vld),
    .ent_rd     (r_rd),
    .ent_load   (r_load),
    .stage_data (hif.stage_data),
    .hit        (w_rs2_hit),
    .ready      (w_rs2_rdy),
    .data       (w_rs2_data)
  );

  assign w_hazard = (w_rs1_hit && !w_rs1_rdy) || (w_rs2_hit && !w_rs2_rdy);

  // A taken branch stuck behind a load must not kill until it actually resolves.
  always_comb begin
    w_ctrl.stall_if_id = (hif.id_valid && w_hazard) || hif.ex_busy;
    w_ctrl.bubble_ex   = hif.id_valid && w_hazard && !hif.ex_busy;
    w_ctrl.kill_if     = hif.id_valid && hif.id_branch_taken && !w_ctrl.stall_if_id;
  end

  assign w_issue = hif.id_valid && hif.id_reg_write &&
                   (hif.id_rd_sel != RA_W'(REG_ZERO)) && !w_ctrl.stall_if_id;

  assign hif.rs1_fwd_en   = w_rs1_hit && w_rs1_rdy;
  assign hif.rs1_fwd_data = w_rs1_data;
  assign hif.rs2_fwd_en   = w_rs2_hit && w_rs2_rdy;
  assign hif.rs2_fwd_data = w_rs2_data;
  assign hif.stall_if_id  = w_ctrl.stall_if_id;
  assign hif.bubble_ex    = w_ctrl.bubble_ex;
  assign hif.kill_if      = w_ctrl.kill_if;
  assign hif.stall_count  = r_stall_cnt;
  assign hif.kill_count   = r_kill_cnt;

  // Negedge update keeps the scoreboard aligned with the interstage registers.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= '0;
      r_load <= '0;
      r_rd   <= '0;
    end else begin
      if (hif.ex_busy) begin
        r_vld[1]  <= 1'b0;
        r_load[1] <= 1'b0;
        r_rd[1]   <= '0;
      end else begin
        r_vld[0]  <= w_issue;
        r_load[0] <= w_issue && hif.id_is_load;
        r_rd[0]   <= w_issue ? hif.id_rd_sel : '0;
        r_vld[1]  <= r_vld[0];
        r_load[1] <= r_load[0];
        r_rd[1]   <= r_rd[0];
      end
      for (int i = 2; i < DEPTH; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_load[i] <= r_load[i-1];
        r_rd[i]   <= r_rd[i-1];
      end
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_kill_cnt  <= '0;
    end else begin
      if (w_ctrl.stall_if_id && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_ctrl.kill_if && (r_kill_cnt != {CNT_W{1'b1}})) begin
        r_kill_cnt <= r_kill_cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dlx_hazard_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_dlx_hazard_unit                                         |
// | Brief   : Randomised scoreboard bench for dlx_hazard_unit.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_dlx_hazard_unit;
  localparam int XLEN     = 32;
  localparam int RA_W     = 5;
  localparam int DEPTH    = 3;
  localparam int LOAD_RDY = 1;
  localparam int CNT_W    = 16;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  typedef struct {
    bit rst_n, valid, u1, u2, rw, ld, br, busy;
    int rs1, rs2, rd;
    logic [DEPTH*XLEN-1:0] sd;
  } stim_t;

  typedef struct {
    bit f1, f2;
    logic [XLEN-1:0] d1, d2;
    bit st, bu, ki;
    int sc, kc;
  } exp_t;

  // One in-flight producer, by age: 0 = just issued into EX.
  typedef struct { bit vld; int rd; bit ld; } slot_t;

  logic  clk = 1'b0;
  logic  rst_n;
  int    total = 0;
  int    bad   = 0;
  exp_t  q[$];
  slot_t pipe[DEPTH];
  int    m_stall = 0;
  int    m_kill  = 0;

  dlx_hazard_unit_if #(.XLEN(XLEN), .RA_W(RA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) hif ();

  dlx_hazard_unit #(
    .XLEN(XLEN), .RA_W(RA_W), .DEPTH(DEPTH), .LOAD_RDY(LOAD_RDY), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hif   (hif.slave)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endfunction

  // Youngest producer of src decides: forwardable value, or wait for a load.
  function automatic void resolve(input int src, input bit used, input logic [DEPTH*XLEN-1:0] sd,
                                  output bit fwd, output logic [XLEN-1:0] d, output bit wait_ld);
    fwd = 0; d = '0; wait_ld = 0;
    if (!used || src == 0) return;
    for (int age = 0; age < DEPTH; age++) begin
      if (pipe[age].vld && pipe[age].rd == src) begin
        if (pipe[age].ld && age < LOAD_RDY) wait_ld = 1;
        else begin fwd = 1; d = sd[age*XLEN +: XLEN]; end
        return;
      end
    end
  endfunction

  function automatic logic [DEPTH*XLEN-1:0] rand_sd();
    logic [DEPTH*XLEN-1:0] r;
    for (int i = 0; i < DEPTH; i++) r[i*XLEN +: XLEN] = $urandom;
    return r;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.rst_n = 1; s.valid = 0; s.u1 = 0; s.u2 = 0; s.rw = 0; s.ld = 0; s.br = 0; s.busy = 0;
    s.rs1 = 0; s.rs2 = 0; s.rd = 0; s.sd = rand_sd();
    return s;
  endfunction

  function automatic stim_t instr(input int rd, input bit rw, input bit ld, input int rs1,
                                  input bit u1, input int rs2, input bit u2, input bit br);
    stim_t s = idle();
    s.valid = 1; s.rd = rd; s.rw = rw; s.ld = ld;
    s.rs1 = rs1; s.u1 = u1; s.rs2 = rs2; s.u2 = u2; s.br = br;
    return s;
  endfunction

  task automatic cycle(input stim_t s);
    exp_t e;
    bit   h1, h2, hz, issue;
    @(posedge clk); #1;
    rst_n               = s.rst_n;
    hif.id_valid        = s.valid;
    hif.id_rs1_sel      = RA_W'(s.rs1);
    hif.id_rs1_used     = s.u1;
    hif.id_rs2_sel      = RA_W'(s.rs2);
    hif.id_rs2_used     = s.u2;
    hif.id_rd_sel       = RA_W'(s.rd);
    hif.id_reg_write    = s.rw;
    hif.id_is_load      = s.ld;
    hif.id_branch_taken = s.br;
    hif.ex_busy         = s.busy;
    hif.stage_data      = s.sd;
    if (!s.rst_n) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] = '{0, 0, 0};
      m_stall = 0; m_kill = 0;
    end
    resolve(s.rs1, s.u1, s.sd, e.f1, e.d1, h1);
    resolve(s.rs2, s.u2, s.sd, e.f2, e.d2, h2);
    hz   = s.valid && (h1 || h2);
    e.st = hz || s.busy;
    e.bu = hz && !s.busy;
    e.ki = s.valid && s.br && !e.st;
    e.sc = m_stall;
    e.kc = m_kill;
    q.push_back(e);
    if (s.rst_n) begin
      if (e.st && m_stall < CNT_MAX) m_stall++;
      if (e.ki && m_kill < CNT_MAX) m_kill++;
      issue = s.valid && s.rw && s.rd != 0 && !e.st;
      if (s.busy) begin
        for (int i = DEPTH - 1; i >= 2; i--) pipe[i] = pipe[i-1];
        pipe[1] = '{0, 0, 0};
      end else begin
        for (int i = DEPTH - 1; i >= 1; i--) pipe[i] = pipe[i-1];
        pipe[0] = issue ? '{1, s.rd, s.ld} : '{0, 0, 0};
      end
    end
  endtask

  // Monitor: outputs are valid every cycle, sampled well before the negedge update.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #3;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rs1_fwd_en", 32'(hif.rs1_fwd_en), 32'(e.f1));
        if (e.f1) chk("rs1_fwd_data", hif.rs1_fwd_data, e.d1);
        chk("rs2_fwd_en", 32'(hif.rs2_fwd_en), 32'(e.f2));
        if (e.f2) chk("rs2_fwd_data", hif.rs2_fwd_data, e.d2);
        chk("stall_if_id", 32'(hif.stall_if_id), 32'(e.st));
        chk("bubble_ex", 32'(hif.bubble_ex), 32'(e.bu));
        chk("kill_if", 32'(hif.kill_if), 32'(e.ki));
        chk("stall_count", 32'(hif.stall_count), 32'(e.sc));
        chk("kill_count", 32'(hif.kill_count), 32'(e.kc));
      end
    end
  end

  initial begin
    stim_t s;
    rst_n = 1'b0;
    hif.id_valid = 0; hif.id_rs1_sel = '0; hif.id_rs1_used = 0; hif.id_rs2_sel = '0;
    hif.id_rs2_used = 0; hif.id_rd_sel = '0; hif.id_reg_write = 0; hif.id_is_load = 0;
    hif.id_branch_taken = 0; hif.ex_busy = 0; hif.stage_data = '0;

    s = idle(); s.rst_n = 0;
    cycle(s); cycle(s);

    // Reset while a load-use stall is pending
    cycle(instr(3, 1, 0, 0, 0, 0, 0, 0));
    cycle(instr(5, 1, 1, 0, 0, 0, 0, 0));
    s = instr(6, 1, 0, 5, 1, 0, 0, 0); s.busy = 1; cycle(s);
    s.busy = 0; s.rst_n = 0; cycle(s);
    cycle(idle());

    // add r3 ; add r4,r3,r3
    cycle(instr(3, 1, 0, 0, 0, 0, 0, 0));
    s = instr(4, 1, 0, 3, 1, 3, 1, 0); s.sd[XLEN-1:0] = 32'h0000_0010; cycle(s);

    // lw r5 ; add r6,r5
    cycle(instr(5, 1, 1, 0, 0, 0, 0, 0));
    s = instr(6, 1, 0, 5, 1, 0, 0, 0); cycle(s);
    s.sd[2*XLEN-1:XLEN] = 32'hDEAD_BEEF; cycle(s);

    // lw r5 ; beqz r5 taken
    cycle(instr(5, 1, 1, 0, 0, 0, 0, 0));
    s = instr(0, 0, 0, 5, 1, 0, 0, 1); cycle(s); cycle(s);

    // multi-cycle EX holds entry 0 for three cycles
    cycle(instr(8, 1, 0, 0, 0, 0, 0, 0));
    s = instr(9, 1, 0, 8, 1, 0, 0, 0); s.busy = 1;
    repeat (3) cycle(s);
    s.busy = 0; cycle(s);
    cycle(idle());

    // r0 is never forwarded
    cycle(instr(0, 1, 0, 0, 0, 0, 0, 0));
    cycle(instr(1, 1, 0, 0, 1, 0, 1, 0));

    // two writers of r7 in EX and WB
    cycle(instr(7, 1, 0, 0, 0, 0, 0, 0));
    cycle(idle());
    cycle(instr(7, 1, 0, 0, 0, 0, 0, 0));
    cycle(instr(2, 1, 0, 7, 1, 7, 1, 0));

    // younger unready load must not be masked by an older ready copy
    cycle(instr(7, 1, 0, 0, 0, 0, 0, 0));
    cycle(instr(7, 1, 1, 0, 0, 0, 0, 0));
    s = instr(2, 1, 0, 0, 0, 7, 1, 0); cycle(s); cycle(s);

    for (int n = 0; n < 500; n++) begin
      s = idle();
      s.rst_n = ($urandom_range(0, 99) != 0);
      s.valid = ($urandom_range(0, 9) != 0);
      s.rs1   = $urandom_range(0, 7);
      s.u1    = ($urandom_range(0, 3) != 0);
      s.rs2   = $urandom_range(0, 7);
      s.u2    = ($urandom_range(0, 1) != 0);
      s.rd    = $urandom_range(0, 7);
      s.rw    = ($urandom_range(0, 3) != 0);
      s.ld    = ($urandom_range(0, 2) == 0);
      s.br    = ($urandom_range(0, 5) == 0);
      s.busy  = ($urandom_range(0, 9) == 0);
      cycle(s);
    end

    // saturate the stall counter
    s = idle(); s.busy = 1;
    repeat (CNT_MAX + 5) cycle(s);
    s.busy = 0;
    repeat (3) cycle(s);

    @(posedge clk); #5;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: got %0d leftover expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
